// File: rtl/scan_chain_driver.sv
// scan_chain_driver
//   Drives one load / latch / capture / unload transaction on a serial scan
//   chain. On an accepted start the parallel word din is shifted into the
//   chain MSB first, transferred to the design inputs with a latch strobe,
//   the design outputs are captured back into the chain, and the chain is
//   shifted out into dout. Every scan bit uses two clk cycles: phase 0 holds
//   scan_clk low with data stable, phase 1 raises scan_clk.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          request a transaction (honoured only in IDLE)
//   din            parallel word shifted into the chain, sampled at acceptance
//   busy           high while a transaction is in progress (not in DONE)
//   done           one-cycle completion pulse
//   dout           word captured from the chain, updated in the DONE cycle
//   scan_clk       chain shift clock
//   scan_data_out  serial data into the chain head
//   scan_data_in   serial data from the chain tail
//   scan_select    1 = chain flops capture the design outputs
//   scan_latch_en  transfers chain contents to the design inputs
module scan_chain_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             scan_clk,
    output logic             scan_data_out,
    input  logic             scan_data_in,
    output logic             scan_select,
    output logic             scan_latch_en
);

    localparam int                CNT_W      = $clog2(2 * WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_PHASE = CNT_W'(2 * WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        LATCH,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;     // cycle index inside the current state
    logic [WIDTH-1:0]  sr_q, sr_d;       // outgoing word, MSB is the bit on the wire
    logic [WIDTH-1:0]  cap_q, cap_d;     // incoming word, filled from the LSB
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              sdo_q, sdo_d;
    logic              ssel_q, ssel_d;
    logic              sle_q, sle_d;

    // Outputs are computed for the state being entered, so each registered
    // output lines up with the state it belongs to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        cap_d   = cap_q;
        dout_d  = dout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sclk_d  = 1'b0;
        sdo_d   = 1'b0;
        ssel_d  = 1'b0;
        sle_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT_IN;
                    cnt_d   = '0;
                    sr_d    = din;
                    cap_d   = '0;
                    busy_d  = 1'b1;
                    sdo_d   = din[WIDTH-1];
                end
            end

            SHIFT_IN: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_PHASE) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                    sle_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q[0]) begin
                        // End of phase 1: present the next bit in phase 0.
                        sr_d  = sr_q << 1;
                        sdo_d = sr_d[WIDTH-1];
                    end else begin
                        sclk_d = 1'b1;
                        sdo_d  = sr_q[WIDTH-1];
                    end
                end
            end

            LATCH: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = CNT_ONE;
                end else begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    ssel_d  = 1'b1;
                end
            end

            CAPTURE: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d  = CNT_ONE;
                    ssel_d = 1'b1;
                    sclk_d = 1'b1;
                end else begin
                    state_d = SHIFT_OUT;
                    cnt_d   = '0;
                end
            end

            SHIFT_OUT: begin
                busy_d = 1'b1;
                // The chain tail is sampled as each phase 1 closes.
                if (cnt_q[0]) begin
                    cap_d = (cap_q << 1) | WIDTH'(scan_data_in);
                end
                if (cnt_q == LAST_PHASE) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = cap_d;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    sclk_d = ~cnt_q[0];
                end
            end

            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            cap_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            ssel_q  <= 1'b0;
            sle_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            cap_q   <= cap_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            ssel_q  <= ssel_d;
            sle_q   <= sle_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign dout          = dout_q;
    assign scan_clk      = sclk_q;
    assign scan_data_out = sdo_q;
    assign scan_select   = ssel_q;
    assign scan_latch_en = sle_q;

endmodule

// File: doc/scan_chain_driver.md
SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of bits in the scan chain.
REQ-002 clk  input  1  SHALL be the single system clock, with all state updating on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request one load/capture/unload transaction.
REQ-005 din  input  WIDTH  SHALL be the data to shift into the chain.
REQ-006 busy  output  1  SHALL be high while a transaction is in progress.
REQ-007 done  output  1  SHALL be a one-cycle pulse marking transaction completion.
REQ-008 dout  output  WIDTH  SHALL be the data captured from the chain.
REQ-009 scan_clk  output  1  SHALL be the chain shift clock.
REQ-010 scan_data_out  output  1  SHALL be the serial data into the chain.
REQ-011 scan_data_in  input  1  SHALL be the serial data from the chain tail.
REQ-012 scan_select  output  1  SHALL select capture, with 1 meaning chain flops load the design outputs.
REQ-013 scan_latch_en  output  1  SHALL transfer chain contents to the design inputs.

Function
REQ-014 The FSM SHALL implement the states IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT and DONE.
REQ-015 In IDLE, start=1 on a rising edge SHALL register din into an internal shift register and move to SHIFT_IN; start=0 SHALL leave the block in IDLE.
REQ-016 Each scan bit SHALL take 2 clk cycles: phase 0 drives scan_clk=0 with data stable, and phase 1 drives scan_clk=1.
REQ-017 SHIFT_IN SHALL last 2*WIDTH cycles and drive scan_data_out MSB first (din[WIDTH-1] first), holding each bit for both of its phases.
REQ-018 LATCH SHALL last 2 cycles: scan_latch_en=1 in the first cycle and 0 in the second, with scan_clk=0 throughout.
REQ-019 CAPTURE SHALL last 2 cycles: scan_select=1 in both, scan_clk=0 in the first and 1 in the second.
REQ-020 scan_select SHALL be 0 in every state other than CAPTURE.
REQ-021 SHIFT_OUT SHALL last 2*WIDTH cycles, sampling scan_data_in at the end of each phase 1 and shifting it into the LSB of the capture register.
REQ-022 The first bit received in SHIFT_OUT SHALL end in dout[WIDTH-1].
REQ-023 scan_data_out SHALL be 0 in every state other than SHIFT_IN.
REQ-024 DONE SHALL last 1 cycle: done=1, busy=0, dout updated with the capture register; the next state SHALL be IDLE.
REQ-025 busy SHALL be 1 in SHIFT_IN, LATCH, CAPTURE and SHIFT_OUT, and 0 in IDLE and DONE.
REQ-026 Latency: with start accepted at edge N, done SHALL be high in cycle N+4*WIDTH+5 (cycle N+37 for WIDTH=8).
REQ-027 start SHALL be ignored while busy=1 and during DONE; no queuing.
REQ-028 din SHALL be sampled only at acceptance; later din changes SHALL NOT affect the transaction.
REQ-029 dout SHALL hold its previous value until DONE.
REQ-030 Bit and phase counters SHALL be sized ceil(log2(2*WIDTH))+1 and SHALL NOT wrap within a state.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and set the following outputs to 0: busy, done, dout, scan_clk, scan_data_out, scan_select, scan_latch_en.
REQ-032 rst_n=0 SHALL also clear all internal registers.
REQ-033 Reset asserted mid-transaction SHALL abort the transaction without a done pulse.
REQ-034 After rst_n rises, the first start SHALL be accepted no earlier than the first rising clk edge.

Verification
REQ-035 Scenario: WIDTH=8, din=0xA5, chain model loops design outputs = inputs -> scan_data_out sequence 1,0,1,0,0,1,0,1; done at cycle 37; dout=0xA5.
REQ-036 Scenario: chain model returns constant 0x3C -> dout=0x3C; scan_select high in exactly 2 cycles; scan_latch_en high in exactly 1 cycle.
REQ-037 Scenario: start held high for 40 cycles -> exactly one transaction completes; a second starts only after returning to IDLE.
REQ-038 Scenario: din changed to 0xFF at cycle 3 after a start with din=0x0F -> shifted sequence still reflects 0x0F.
REQ-039 Scenario: rst_n pulsed low at cycle 20 -> all outputs 0 immediately, no done, dout stays 0; next start completes normally.
REQ-040 Scenario: back-to-back start asserted in the DONE cycle -> ignored; start in the following IDLE cycle accepted.
